mac_window_engine: RTL and testbench

- Datapath responder to the convolution FSM controller. It consumes the `start_mac` level and a streamed pixel/weight sample pair, and accumulates exactly KERNEL_SIZE signed products per window.
- It returns a saturated result to downstream logic with a valid/ready handshake.
- It sits between the FSM controller and the output buffer of the convolution accelerator.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/signed_mul_ext.sv | 22 ++
 rtl/mac_window_engine.sv | 136 +++++++++++++
 tb/tb_mac_window_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: state encoding, default sizes, saturation.
package conv_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned KERNEL_SIZE_DEF = 9;
  localparam int unsigned OUT_W_DEF       = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  // Clip a sign-extended value to the signed range of a w-bit result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/signed_mul_ext.sv
// Combinational signed multiply, product sign-extended to the accumulator width.
module signed_mul_ext #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  p
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;

  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign p     = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

endmodule

// File: rtl/mac_window_engine.sv
// Accumulates KERNEL_SIZE signed products per window and hands a saturated sum downstream.
module mac_window_engine
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int unsigned OUT_W       = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_mac,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] pixel_in,
  input  logic signed [DATA_W-1:0] weight_in,
  output logic                     in_ready,
  output logic signed [OUT_W-1:0]  result_out,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     sat_flag,
  output logic                     abort_pulse,
  output logic                     busy
);

  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(KERNEL_SIZE);
  localparam int unsigned CNT_W = $clog2(KERNEL_SIZE);

  logic [1:0]              state, state_d;
  logic signed [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic signed [OUT_W-1:0] result_d;
  logic                    result_valid_d;
  logic                    sat_d;
  logic                    abort_d;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [63:0]      sum_wide;
  logic signed [63:0]      sum_sat;
  logic                    accept;

  signed_mul_ext #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mul (
    .a(pixel_in),
    .b(weight_in),
    .p(prod)
  );

  assign accept   = valid_in && in_ready && start_mac;
  assign sum      = acc + prod;
  assign sum_wide = 64'(sum);
  assign sum_sat  = saturate(sum_wide, OUT_W);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d        = state;
    acc_d          = acc;
    cnt_d          = cnt;
    result_d       = result_out;
    result_valid_d = result_valid;
    sat_d          = sat_flag;
    abort_d        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_d   = prod;
          cnt_d   = CNT_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // Dropping start_mac abandons the window even if a sample is offered.
        if (!start_mac) begin
          acc_d   = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (accept) begin
          if (cnt == CNT_W'(KERNEL_SIZE - 1)) begin
            result_d       = OUT_W'(sum_sat);
            sat_d          = (sum_sat != sum_wide);
            result_valid_d = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
            state_d        = HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
      sat_flag     <= 1'b0;
      abort_pulse  <= 1'b0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      acc          <= acc_d;
      cnt          <= cnt_d;
      result_out   <= result_d;
      result_valid <= result_valid_d;
      sat_flag     <= sat_d;
      abort_pulse  <= abort_d;
      in_ready     <= (state_d != HOLD);
      busy         <= (state_d == ACCUM) || (state_d == HOLD);
    end
  end

endmodule

// File: tb/tb_mac_window_engine.sv
// Directed bench for mac_window_engine: table of full windows plus abort/backpressure/reset sequences.
module tb_mac_window_engine;

  logic              clk;
  logic              rst_n;
  logic              start_mac;
  logic              valid_in;
  logic signed [7:0] pixel_in;
  logic signed [7:0] weight_in;
  logic              in_ready;
  logic signed [15:0] result_out;
  logic              result_valid;
  logic              result_ready;
  logic              sat_flag;
  logic              abort_pulse;
  logic              busy;

  int n_total;
  int n_pass;

  mac_window_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_mac   (start_mac),
    .valid_in    (valid_in),
    .pixel_in    (pixel_in),
    .weight_in   (weight_in),
    .in_ready    (in_ready),
    .result_out  (result_out),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .sat_flag    (sat_flag),
    .abort_pulse (abort_pulse),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pixel;
    int weight;
    bit gaps;
    bit ramp;
    int exp_result;
    bit exp_sat;
  } win_vec_t;

  win_vec_t vecs[6];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams one full window, then completes the handshake.
  task automatic run_window(input win_vec_t v);
    for (int i = 0; i < 9; i++) begin
      if (v.gaps && i > 0) begin
        valid_in = 1'b0;
        step();
        check("bubble_no_result", int'(result_valid), 0);
      end
      valid_in  = 1'b1;
      pixel_in  = v.ramp ? 8'(i + 1) : 8'(v.pixel);
      weight_in = 8'(v.weight);
      step();
      if (i < 8) begin
        check("early_valid", int'(result_valid), 0);
      end
    end
    valid_in = 1'b0;
    check("win_valid", int'(result_valid), 1);
    check("win_result", int'(result_out), v.exp_result);
    check("win_sat", int'(sat_flag), int'(v.exp_sat));
    check("win_in_ready_hold", int'(in_ready), 0);
    check("win_busy_hold", int'(busy), 1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("win_valid_cleared", int'(result_valid), 0);
    check("win_in_ready_idle", int'(in_ready), 1);
    check("win_busy_idle", int'(busy), 0);
  endtask

  task automatic feed(input int n, input int px, input int wt);
    for (int i = 0; i < n; i++) begin
      valid_in  = 1'b1;
      pixel_in  = 8'(px);
      weight_in = 8'(wt);
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_ready"}, int'(in_ready), 0);
    check({name, "_result"}, int'(result_out), 0);
    check({name, "_valid"}, int'(result_valid), 0);
    check({name, "_sat"}, int'(sat_flag), 0);
    check({name, "_abort"}, int'(abort_pulse), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] held;
    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{2, 3, 1'b0, 1'b0, 54, 1'b0};
    vecs[1] = '{-128, -128, 1'b0, 1'b0, 32767, 1'b1};
    vecs[2] = '{-128, 127, 1'b0, 1'b0, -32768, 1'b1};
    vecs[3] = '{1, 1, 1'b0, 1'b0, 9, 1'b0};
    vecs[4] = '{0, 1, 1'b1, 1'b1, 45, 1'b0};
    vecs[5] = '{-5, 7, 1'b1, 1'b0, -315, 1'b0};

    rst_n        = 1'b0;
    start_mac    = 1'b0;
    valid_in     = 1'b0;
    pixel_in     = '0;
    weight_in    = '0;
    result_ready = 1'b0;
    #23;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check("post_reset_in_ready", int'(in_ready), 1);
    check("post_reset_busy", int'(busy), 0);

    start_mac = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_window(vecs[k]);
    end

    // result_ready while idle is ignored
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("idle_ready_valid", int'(result_valid), 0);
    check("idle_ready_busy", int'(busy), 0);

    // Abort after four samples
    feed(4, 7, 7);
    check("abort_busy_before", int'(busy), 1);
    start_mac = 1'b0;
    valid_in  = 1'b1;
    step();
    valid_in = 1'b0;
    check("abort_pulse_hi", int'(abort_pulse), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_no_valid", int'(result_valid), 0);
    step();
    check("abort_pulse_lo", int'(abort_pulse), 0);
    check("abort_no_valid2", int'(result_valid), 0);
    start_mac = 1'b1;
    run_window(vecs[3]);

    // Ninth sample coincides with start_mac falling: abort, not a result
    feed(8, 3, 3);
    start_mac = 1'b0;
    valid_in  = 1'b1;
    step();
    valid_in = 1'b0;
    check("late_abort_pulse", int'(abort_pulse), 1);
    check("late_abort_valid", int'(result_valid), 0);
    step();
    check("late_abort_valid2", int'(result_valid), 0);
    start_mac = 1'b1;
    run_window(vecs[0]);

    // Backpressure: result held, offered samples not consumed
    feed(9, 4, -3);
    check("bp_valid", int'(result_valid), 1);
    check("bp_result", int'(result_out), -108);
    held = result_out;
    valid_in  = 1'b1;
    pixel_in  = 8'sd50;
    weight_in = 8'sd50;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_stable", int'(result_out), int'(held));
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_valid_held", int'(result_valid), 1);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    valid_in     = 1'b0;
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_valid", int'(result_valid), 0);
    check("bp_not_consumed", int'(busy), 0);
    run_window(vecs[3]);

    // Reset mid-window
    feed(5, 9, 9);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    #10;
    rst_n = 1'b1;
    step();
    run_window('{2, 2, 1'b0, 1'b0, 36, 1'b0});

    // Reset while holding a result
    feed(9, 1, 2);
    check("holdreset_pre_valid", int'(result_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("holdreset");
    #10;
    rst_n = 1'b1;
    step();
    run_window(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
